// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Contents: FSM state enum, BCD digit width, add-3 threshold and the
// pow10_minus1() helper that gives the largest value D digits can show.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned ADD3_THRESH = 5;

  // 10^d - 1, evaluated at elaboration for the overflow limit.
  function automatic longint unsigned pow10_minus1(input int unsigned d);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < d; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Combinational double-dabble digit correction: digits of 5 or more get 3
// added so the following left shift carries correctly into the next digit.
// Ports:
//   digit_i  BCD digit before correction
//   digit_c  corrected digit (combinational)
module bcd_add3
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_c
);

  assign digit_c = (digit_i >= BCD_DIGIT_W'(ADD3_THRESH))
                 ? digit_i + BCD_DIGIT_W'(3)
                 : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a start/busy/done handshake.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       conversion request, accepted in IDLE or DONE
//   bin_in      unsigned W-bit value captured when start is accepted
//   busy        conversion in progress
//   done        one-cycle completion pulse; results valid from this cycle
//   bcd_out     D packed BCD digits, digit 0 in bits [3:0]
//   ovf         captured value exceeded 10^D-1 (bcd_out saturated to 9s)
//   blank       leading-zero mask per digit
// Optional feature macro: BIN_TO_BCD_LZB_EN enables leading-zero blanking;
// when undefined, blank is tied low.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int unsigned W = 9,
  parameter int unsigned D = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [W-1:0]             bin_in,
  output logic                     busy,
  output logic                     done,
  output logic [BCD_DIGIT_W*D-1:0] bcd_out,
  output logic                     ovf,
  output logic [D-1:0]             blank
);

  localparam int unsigned     ACC_W     = BCD_DIGIT_W * D;
  localparam int unsigned     CNT_W     = $clog2(W + 1);
  localparam longint unsigned OVF_LIMIT = pow10_minus1(D);
  localparam logic [ACC_W-1:0] ALL_NINES = {D{4'h9}};

  state_e             state_q;
  logic [W-1:0]       sr_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_next_q;
  logic               busy_q;
  logic               done_q;
  logic [ACC_W-1:0]   bcd_q;
  logic               ovf_q;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W+W-1:0] pair_d;
  logic [ACC_W-1:0]   acc_d;
  logic [W-1:0]       sr_d;
  logic               ovf_in_c;
  logic               last_shift_c;

  // Per-digit add-3 correction ahead of each shift.
  for (genvar g = 0; g < D; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_c (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Shift the {accumulator, shift register} pair; the accumulator MSB drops.
  assign pair_d = {acc_adj, sr_q} << 1;
  assign acc_d  = pair_d[ACC_W+W-1:W];
  assign sr_d   = pair_d[W-1:0];

  // 64-bit compare holds both operands; folds to 0 when 10^D-1 >= 2^W-1.
  assign ovf_in_c     = (64'(bin_in) > OVF_LIMIT);
  assign last_shift_c = (state_q == SHIFT) && (cnt_q == CNT_W'(W - 1));

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sr_q       <= bin_in;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_next_q <= ovf_in_c;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_shift_c) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= ovf_next_q ? ALL_NINES : acc_d;
            ovf_q   <= ovf_next_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

`ifdef BIN_TO_BCD_LZB_EN
  localparam logic [D-1:0] BLANK_RST = ~D'(1);

  logic [D-1:0] blank_q;
  logic [D-1:0] blank_d;
  logic         zero_run;

  // Digit i (i>=1) blanks when it and every higher digit are zero.
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      zero_run   = zero_run && (acc_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_d[i] = zero_run;
    end
    if (ovf_next_q) begin
      blank_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= BLANK_RST;
    end else if (last_shift_c) begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a W=9/D=3 instance and a W=8/D=2
// instance (overflow/saturation) sharing clock and reset.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start9, start8;
  logic [8:0]  bin9;
  logic [7:0]  bin8;
  logic        busy9, done9, ovf9;
  logic [11:0] bcd9;
  logic [2:0]  blank9;
  logic        busy8, done8, ovf8;
  logic [7:0]  bcd8;
  logic [1:0]  blank8;

  int total = 0;
  int bad   = 0;
  int overlap = 0;

`ifdef BIN_TO_BCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  bin_to_bcd_seq #(.W(9), .D(3)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .start(start9), .bin_in(bin9),
    .busy(busy9), .done(done9), .bcd_out(bcd9), .ovf(ovf9), .blank(blank9)
  );

  bin_to_bcd_seq #(.W(8), .D(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bin_in(bin8),
    .busy(busy8), .done(done8), .bcd_out(bcd8), .ovf(ovf8), .blank(blank8)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && ((busy9 && done9) || (busy8 && done8))) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] eb(input logic [2:0] v);
    return LZB ? v : 3'b000;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? done8 : done9;
  endfunction

  task automatic wait_done(input bit sel, inout int n);
    while (!get_done(sel) && n < 40) begin
      tick();
      n++;
    end
  endtask

  // sel=0 -> W=9/D=3 instance, sel=1 -> W=8/D=2 instance.
  task automatic convert(input bit sel, input logic [8:0] val, input logic [11:0] ebcd,
                         input logic eovf, input logic [2:0] eblk, input string tag);
    int n;
    n = 0;
    if (sel) begin start8 = 1'b1; bin8 = val[7:0]; end
    else     begin start9 = 1'b1; bin9 = val;      end
    tick();
    start8 = 1'b0;
    start9 = 1'b0;
    chk({tag, "_busy"}, 32'(sel ? busy8 : busy9), 32'(1));
    wait_done(sel, n);
    chk({tag, "_lat"}, 32'(n), sel ? 32'(8) : 32'(9));
    chk({tag, "_bcd"}, sel ? 32'(bcd8) : 32'(bcd9), 32'(ebcd));
    chk({tag, "_ovf"}, 32'(sel ? ovf8 : ovf9), 32'(eovf));
    chk({tag, "_blank"}, sel ? 32'(blank8) : 32'(blank9), 32'(eb(eblk)));
    tick();
    chk({tag, "_pulse"}, 32'(get_done(sel)), 32'(0));
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    start9 = 1'b0;
    start8 = 1'b0;
    bin9   = '0;
    bin8   = '0;
    #12;
    chk("rst_busy",  32'(busy9),  32'(0));
    chk("rst_done",  32'(done9),  32'(0));
    chk("rst_bcd",   32'(bcd9),   32'(0));
    chk("rst_ovf",   32'(ovf9),   32'(0));
    chk("rst_blank", 32'(blank9), 32'(eb(3'b110)));
    rst_n = 1'b1;
    tick();

    convert(1'b0, 9'd0,   12'h000, 1'b0, 3'b110, "c0");
    convert(1'b0, 9'd255, 12'h255, 1'b0, 3'b000, "c255");
    convert(1'b0, 9'd510, 12'h510, 1'b0, 3'b000, "c510");
    convert(1'b0, 9'd511, 12'h511, 1'b0, 3'b000, "c511");
    convert(1'b0, 9'd40,  12'h040, 1'b0, 3'b100, "c40");
    convert(1'b1, 9'd100, 12'h099, 1'b1, 3'b000, "o100");
    convert(1'b1, 9'd99,  12'h099, 1'b0, 3'b000, "o99");
    convert(1'b1, 9'd5,   12'h005, 1'b0, 3'b010, "o5");
    convert(1'b1, 9'd255, 12'h099, 1'b1, 3'b000, "o255");

    // Second start during SHIFT must be ignored.
    start9 = 1'b1; bin9 = 9'd37;
    tick();
    start9 = 1'b0;
    tick();
    tick();
    start9 = 1'b1; bin9 = 9'd400;
    tick();
    start9 = 1'b0; bin9 = '0;
    n = 3;
    wait_done(1'b0, n);
    chk("ign_lat",   32'(n),      32'(9));
    chk("ign_bcd",   32'(bcd9),   32'(12'h037));
    chk("ign_blank", 32'(blank9), 32'(eb(3'b100)));
    tick();
    chk("ign_idle",  32'(busy9),  32'(0));
    chk("ign_pulse", 32'(done9),  32'(0));

    // Back-to-back: start held high through the first done cycle.
    start9 = 1'b1; bin9 = 9'd7;
    tick();
    bin9 = 9'd128;
    n = 0;
    wait_done(1'b0, n);
    chk("b2b1_lat", 32'(n),    32'(9));
    chk("b2b1_bcd", 32'(bcd9), 32'(12'h007));
    tick();
    start9 = 1'b0;
    chk("b2b2_busy", 32'(busy9), 32'(1));
    n = 0;
    wait_done(1'b0, n);
    chk("b2b2_lat",   32'(n),      32'(9));
    chk("b2b2_bcd",   32'(bcd9),   32'(12'h128));
    chk("b2b2_blank", 32'(blank9), 32'(eb(3'b000)));
    tick();

    // Reset in the middle of a conversion.
    start9 = 1'b1; bin9 = 9'd300;
    tick();
    start9 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_busy",  32'(busy9),  32'(0));
    chk("mr_done",  32'(done9),  32'(0));
    chk("mr_bcd",   32'(bcd9),   32'(0));
    chk("mr_ovf",   32'(ovf9),   32'(0));
    chk("mr_blank", 32'(blank9), 32'(eb(3'b110)));
    chk("mr_bcd8",  32'(bcd8),   32'(0));
    #2;
    rst_n = 1'b1;
    n = 0;
    repeat (15) begin
      tick();
      if (done9) n++;
    end
    chk("mr_spurious", 32'(n), 32'(0));
    convert(1'b0, 9'd42, 12'h042, 1'b0, 3'b100, "c42");

    chk("busy_done_excl", 32'(overlap), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter for the calculator datapath. Takes an unsigned binary result (sum or product) and produces packed BCD digits, one 4-bit nibble per decimal digit, for the seven-segment digit decoders. Uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, under a start/busy/done handshake.

## Interface
- W, 9: input binary width; 9 covers the full 8-bit sum range 0..510.
- D, 3: number of BCD output digits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request to convert; sampled on the rising edge.
- bin_in  input  W  unsigned value; captured on the edge where start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out and ovf are valid from this cycle.
- bcd_out  output  4*D  digit i occupies bits [4i+3:4i]; digit 0 is least significant.
- ovf  output  1  captured value exceeds 10^D − 1.
- blank  output  D  leading-zero mask, one bit per digit (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE or DONE, start=1: capture bin_in into the shift register. Clear the BCD accumulator and bit counter. Compute ovf_next = (bin_in > 10^D − 1), using a comparison wide enough to hold both operands. If 10^D − 1 ≥ 2^W − 1, ovf_next is constantly 0. Go to SHIFT.
- IDLE, start=0: stay in IDLE. DONE, start=0: go to IDLE.
- SHIFT, each edge:
  - Every accumulator digit ≥ 5 gets 3 added.
  - The {accumulator, shift register} pair then shifts left by 1, and the counter increments.
  - On the edge that performs shift number W, go to DONE.
  - On that same edge, load bcd_out from the accumulator (all digits 9 if ovf_next), load ovf and blank, and set done.
- start is ignored while in SHIFT. No queueing; bin_in changes during SHIFT have no effect.
- bcd_out, ovf and blank hold their values until the next completion or reset.
- Accumulator width is 4*D bits. When ovf_next is set, bits shifted out of the top are discarded and the result is replaced by saturation.
- Counter width is clog2(W+1).

## Timing
- Reset (asynchronous assert, release synchronous to clk):
  - State goes to IDLE.
  - busy=0, done=0, ovf=0, bcd_out=0, blank = all-ones except bit 0 (display shows "0").
- An in-flight conversion is discarded on reset. No done is emitted for it.
- Start accepted on edge k:
  - busy=1 after edge k through the cycle before done.
  - done=1 for exactly the one cycle after edge k+W. busy=0 in that cycle.
  - Latency is W+1 edges from capture to results visible.
- Back-to-back: start=1 during the done cycle is accepted. done and busy are then never high together, and throughput is one result per W+1 cycles.
- done is registered, not combinational from state.

## Configuration
- BIN_TO_BCD_LZB_EN defined:
  - blank[i]=1 for each digit i ≥ 1 where that digit and all higher digits are 0.
  - blank[0] is always 0.
  - When ovf=1, blank is all 0s.
  - blank updates only on the done edge and at reset.
- BIN_TO_BCD_LZB_EN undefined: blank is tied to all 0s (port retained); no blanking logic is synthesised.

## Structure
- Shared package bin_to_bcd_pkg holds:
  - state enum (IDLE, SHIFT, DONE)
  - BCD_DIGIT_W = 4
  - ADD3_THRESH = 5
  - function pow10_minus1(D) for the overflow limit
- One sub-module, bcd_add3: purely combinational 4-bit digit correction (in ≥ 5 → in+3, else in). Instantiated D times in a generate loop.
- The FSM, counter, shift register and output registers live in bin_to_bcd_seq.

## Test plan
- W=9, D=3; start with bin_in=0 → done after 10 edges; bcd_out=0x000, ovf=0, blank=3'b110 (LZB on).
- bin_in=255 → bcd_out=0x255; bin_in=510 → 0x510; bin_in=511 → 0x511; blank=3'b000 for all three.
- W=8, D=2; bin_in=100 → ovf=1, bcd_out=0x99, blank=2'b00. bin_in=99 → ovf=0, bcd_out=0x99.
- Pulse start with 37 and re-pulse start with 400 at cycle 3 → single done after 10 edges with bcd_out=0x037; the second start is ignored.
- Back-to-back: start with 7 held through its done cycle with bin_in=128 → second done exactly 10 edges later, bcd_out=0x128. busy and done are never both high.
- Assert rst_n=0 mid-SHIFT → all outputs at reset values immediately. After release, no spurious done appears, and the next conversion of 42 gives 0x042.
